hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 133 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
//
// Purpose:
//   Detects pipeline hazards at the ID stage and freezes the front end for
//   them. The PC and IF/ID register are held and a bubble is pushed into
//   ID/EX. Three hazard sources are detected:
//     - load-use: a load in EX writes a register that ID reads
//     - multiply/divide: the multicycle unit is busy while ID holds another
//       mult/div or an mfhi/mflo
//     - branch-in-ID (optional, macro HAZARD_BRANCH_ID_EN): a beq/bne in ID
//       needs a value that is still being produced by EX or by a load in MEM
//
// Configuration macro:
//   HAZARD_BRANCH_ID_EN  enables the branch-in-ID hazard term. When it is not
//                        defined, EX_RegWrite, EX_rd, MEM_MemRead, MEM_rd and
//                        ID_Op are still ports but are ignored.
//
// Parameters:
//   REG_W       register specifier width
//   OP_W        opcode width
//   MULDIV_LAT  busy cycles of the multiply/divide unit (1..15)
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   EX_MemRead, EX_rt          load in EX and its destination
//   EX_RegWrite, EX_rd         register write in EX and its destination
//   MEM_MemRead, MEM_rd        load in MEM and its destination
//   ID_rs, ID_rt, ID_Op        ID-stage sources and opcode
//   ID_MulDiv, ID_ReadHiLo     ID holds mult/div, ID holds mfhi/mflo
//   PC_WriteEn, IFID_WriteEn   1 = advance PC / IF-ID register
//   Stall_flush                1 = insert bubble into ID-EX
//   MulDiv_Busy                multicycle unit occupied
// ----------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int REG_W      = 5,
   parameter int OP_W       = 6,
   parameter int MULDIV_LAT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_rt,
   input  logic             EX_RegWrite,
   input  logic [REG_W-1:0] EX_rd,
   input  logic             MEM_MemRead,
   input  logic [REG_W-1:0] MEM_rd,
   input  logic [REG_W-1:0] ID_rs,
   input  logic [REG_W-1:0] ID_rt,
   input  logic [OP_W-1:0]  ID_Op,
   input  logic             ID_MulDiv,
   input  logic             ID_ReadHiLo,
   output logic             PC_WriteEn,
   output logic             IFID_WriteEn,
   output logic             Stall_flush,
   output logic             MulDiv_Busy
);

   localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_LAT);

   logic [3:0] busyCount;
   logic       loadUseHazard;
   logic       mulDivHazard;
   logic       branchHazard;
   logic       stall;

   // A load in EX only matters when its destination is a real register
   // (r0 is hardwired) and the instruction in ID reads that register.
   assign loadUseHazard = EX_MemRead && (EX_rt != '0) &&
                          ((EX_rt == ID_rs) || (EX_rt == ID_rt));

   // While the multicycle unit is running, neither a new mult/div nor a
   // HI/LO read may leave ID.
   assign mulDivHazard = (busyCount != 4'd0) && (ID_MulDiv || ID_ReadHiLo);

`ifdef HAZARD_BRANCH_ID_EN
   localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000101);

   logic isBranch;
   logic exConflict;
   logic memConflict;

   // Branches resolve in ID, so they need their operands before forwarding
   // from EX or a load still in MEM could deliver them.
   assign isBranch    = (ID_Op == OP_BEQ) || (ID_Op == OP_BNE);
   assign exConflict  = EX_RegWrite && (EX_rd != '0) &&
                        ((EX_rd == ID_rs) || (EX_rd == ID_rt));
   assign memConflict = MEM_MemRead && (MEM_rd != '0) &&
                        ((MEM_rd == ID_rs) || (MEM_rd == ID_rt));
   assign branchHazard = isBranch && (exConflict || memConflict);
`else
   logic unusedBranchInputs;

   // The branch term is compiled out; the inputs are folded together only
   // so that they have a reader.
   assign unusedBranchInputs = ^{ID_Op, EX_RegWrite, EX_rd, MEM_MemRead, MEM_rd};
   assign branchHazard       = 1'b0;
`endif

   assign stall = loadUseHazard || mulDivHazard || branchHazard;

   // Busy counter for the multicycle unit. A mult/div that is itself stalled
   // has not issued yet, so it must not start the count; the count keeps
   // running down while other hazards hold the pipeline. Reset abandons any
   // operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busyCount <= 4'd0;
      end else if (ID_MulDiv && !stall) begin
         busyCount <= BUSY_LOAD;
      end else if (busyCount != 4'd0) begin
         busyCount <= busyCount - 4'd1;
      end
   end

   // Pipeline control is combinational so the stall takes effect in the same
   // cycle the hazard appears. During reset the front end is held frozen and
   // the ID/EX register is kept as a bubble whatever the inputs say.
   always_comb begin
      PC_WriteEn   = !stall;
      IFID_WriteEn = !stall;
      Stall_flush  = stall;
      if (!reset_n) begin
         PC_WriteEn   = 1'b0;
         IFID_WriteEn = 1'b0;
         Stall_flush  = 1'b1;
      end
   end

   assign MulDiv_Busy = (busyCount != 4'd0);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit. The driver applies one stimulus
// vector per cycle and pushes the response that a behavioural model predicts
// into a queue; a monitor on the falling edge pops each entry and compares it
// with what the DUT shows. The model tracks the multicycle unit as "busy until
// cycle N" rather than as a counter.
// ----------------------------------------------------------------------------
module tb_hazard_stall_unit;

   localparam int REG_W      = 5;
   localparam int OP_W       = 6;
   localparam int MULDIV_LAT = 4;

   typedef struct {
      logic             rstN;
      logic             exMemRead;
      logic [REG_W-1:0] exRt;
      logic             exRegWrite;
      logic [REG_W-1:0] exRd;
      logic             memMemRead;
      logic [REG_W-1:0] memRd;
      logic [REG_W-1:0] idRs;
      logic [REG_W-1:0] idRt;
      logic [OP_W-1:0]  idOp;
      logic             idMulDiv;
      logic             idReadHiLo;
   } stim_t;

   typedef struct {
      logic pcEn;
      logic ifidEn;
      logic flush;
      logic busy;
      int   cyc;
   } exp_t;

   logic             clk;
   logic             reset_n;
   logic             EX_MemRead;
   logic [REG_W-1:0] EX_rt;
   logic             EX_RegWrite;
   logic [REG_W-1:0] EX_rd;
   logic             MEM_MemRead;
   logic [REG_W-1:0] MEM_rd;
   logic [REG_W-1:0] ID_rs;
   logic [REG_W-1:0] ID_rt;
   logic [OP_W-1:0]  ID_Op;
   logic             ID_MulDiv;
   logic             ID_ReadHiLo;
   logic             PC_WriteEn;
   logic             IFID_WriteEn;
   logic             Stall_flush;
   logic             MulDiv_Busy;

   exp_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;
   int   cycleNow   = 0;
   int   busyUntil  = 0;

   hazard_stall_unit #(
      .REG_W(REG_W),
      .OP_W(OP_W),
      .MULDIV_LAT(MULDIV_LAT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .EX_MemRead(EX_MemRead),
      .EX_rt(EX_rt),
      .EX_RegWrite(EX_RegWrite),
      .EX_rd(EX_rd),
      .MEM_MemRead(MEM_MemRead),
      .MEM_rd(MEM_rd),
      .ID_rs(ID_rs),
      .ID_rt(ID_rt),
      .ID_Op(ID_Op),
      .ID_MulDiv(ID_MulDiv),
      .ID_ReadHiLo(ID_ReadHiLo),
      .PC_WriteEn(PC_WriteEn),
      .IFID_WriteEn(IFID_WriteEn),
      .Stall_flush(Stall_flush),
      .MulDiv_Busy(MulDiv_Busy)
   );

   // 10-time-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A quiet cycle: reset released, nothing in any stage that could clash.
   function automatic stim_t idle();
      stim_t s;
      s.rstN       = 1'b1;
      s.exMemRead  = 1'b0;
      s.exRt       = '0;
      s.exRegWrite = 1'b0;
      s.exRd       = '0;
      s.memMemRead = 1'b0;
      s.memRd      = '0;
      s.idRs       = '0;
      s.idRt       = '0;
      s.idOp       = 6'b100011;
      s.idMulDiv   = 1'b0;
      s.idReadHiLo = 1'b0;
      return s;
   endfunction

   // Drive one vector just after the rising edge, predict the response from
   // the rules, queue it for the monitor, then advance the model past the
   // next rising edge.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      bit   loadUse;
      bit   mulDiv;
      bit   branch;
      bit   busyNow;
      bit   stall;
      @(posedge clk);
      #1;
      reset_n     = s.rstN;
      EX_MemRead  = s.exMemRead;
      EX_rt       = s.exRt;
      EX_RegWrite = s.exRegWrite;
      EX_rd       = s.exRd;
      MEM_MemRead = s.memMemRead;
      MEM_rd      = s.memRd;
      ID_rs       = s.idRs;
      ID_rt       = s.idRt;
      ID_Op       = s.idOp;
      ID_MulDiv   = s.idMulDiv;
      ID_ReadHiLo = s.idReadHiLo;

      if (!s.rstN) busyUntil = 0;
      busyNow = (cycleNow < busyUntil);
      loadUse = s.exMemRead && (s.exRt != 0) && ((s.exRt == s.idRs) || (s.exRt == s.idRt));
      mulDiv  = busyNow && (s.idMulDiv || s.idReadHiLo);
      branch  = 1'b0;
`ifdef HAZARD_BRANCH_ID_EN
      if (s.idOp == 6'b000100 || s.idOp == 6'b000101) begin
         if (s.exRegWrite && s.exRd != 0 && (s.exRd == s.idRs || s.exRd == s.idRt)) branch = 1'b1;
         if (s.memMemRead && s.memRd != 0 && (s.memRd == s.idRs || s.memRd == s.idRt)) branch = 1'b1;
      end
`endif
      stall = loadUse || mulDiv || branch;

      e.cyc = cycleNow;
      if (!s.rstN) begin
         e.pcEn   = 1'b0;
         e.ifidEn = 1'b0;
         e.flush  = 1'b1;
         e.busy   = 1'b0;
      end else begin
         e.pcEn   = !stall;
         e.ifidEn = !stall;
         e.flush  = stall;
         e.busy   = busyNow;
         // An issued mult/div keeps the unit busy for the next MULDIV_LAT cycles.
         if (s.idMulDiv && !stall) busyUntil = cycleNow + 1 + MULDIV_LAT;
      end
      expQ.push_back(e);
      cycleNow++;
   endtask

   task automatic checkOutput(input string name, input logic actual, input logic required, input int cyc);
      checkCount++;
      if (actual === required) passCount++;
      else $display("[TB] FAIL %s cycle %0d: got %b, expected %b", name, cyc, actual, required);
   endtask

   // Monitor: every falling edge the DUT is presenting the response to the
   // vector driven after the preceding rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("PC_WriteEn",   PC_WriteEn,   e.pcEn,   e.cyc);
         checkOutput("IFID_WriteEn", IFID_WriteEn, e.ifidEn, e.cyc);
         checkOutput("Stall_flush",  Stall_flush,  e.flush,  e.cyc);
         checkOutput("MulDiv_Busy",  MulDiv_Busy,  e.busy,   e.cyc);
      end
   end

   initial begin
      stim_t s;
      reset_n     = 1'b0;
      EX_MemRead  = 1'b0;
      EX_rt       = '0;
      EX_RegWrite = 1'b0;
      EX_rd       = '0;
      MEM_MemRead = 1'b0;
      MEM_rd      = '0;
      ID_rs       = '0;
      ID_rt       = '0;
      ID_Op       = '0;
      ID_MulDiv   = 1'b0;
      ID_ReadHiLo = 1'b0;

      // Reset held with inputs that would otherwise clear the stall or start the unit.
      s = idle(); s.rstN = 1'b0; s.idMulDiv = 1'b1;
      applyStimulus(s);
      s = idle(); s.rstN = 1'b0; s.exMemRead = 1'b1; s.exRt = 5'd3; s.idRs = 5'd3;
      applyStimulus(s);
      applyStimulus(idle());

      // Load-use on r8 stalls one cycle, then the bubble clears EX; r0 never stalls.
      s = idle(); s.exMemRead = 1'b1; s.exRt = 5'd8; s.idRs = 5'd8;
      applyStimulus(s);
      s = idle(); s.idRs = 5'd8;
      applyStimulus(s);
      s = idle(); s.exMemRead = 1'b1; s.exRt = 5'd0; s.idRs = 5'd0; s.idRt = 5'd0;
      applyStimulus(s);
      s = idle(); s.exMemRead = 1'b1; s.exRt = 5'd12; s.idRt = 5'd12;
      applyStimulus(s);

      // Mult accepted, then mfhi waits MULDIV_LAT cycles and proceeds on the next.
      s = idle(); s.idMulDiv = 1'b1;
      applyStimulus(s);
      for (int i = 0; i < MULDIV_LAT + 1; i++) begin
         s = idle(); s.idReadHiLo = 1'b1;
         applyStimulus(s);
      end

      // Mult held by a load-use only starts the unit once it is unstalled.
      s = idle(); s.idMulDiv = 1'b1; s.exMemRead = 1'b1; s.exRt = 5'd9; s.idRs = 5'd9;
      applyStimulus(s);
      s = idle(); s.idMulDiv = 1'b1; s.idRs = 5'd9;
      applyStimulus(s);
      s = idle(); s.idReadHiLo = 1'b1;
      applyStimulus(s);
      // Counter keeps running down under an unrelated load-use stall.
      s = idle(); s.exMemRead = 1'b1; s.exRt = 5'd4; s.idRs = 5'd4;
      applyStimulus(s);
      for (int i = 0; i < MULDIV_LAT; i++) applyStimulus(idle());

      // Reset in the middle of a busy period abandons it; mfhi afterwards is free.
      s = idle(); s.idMulDiv = 1'b1;
      applyStimulus(s);
      applyStimulus(idle());
      s = idle(); s.rstN = 1'b0; s.idReadHiLo = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      s = idle(); s.idReadHiLo = 1'b1;
      applyStimulus(s);

      // Branch operands still being produced in EX or by a load in MEM.
      s = idle(); s.idOp = 6'b000100; s.idRs = 5'd5; s.exRegWrite = 1'b1; s.exRd = 5'd5;
      applyStimulus(s);
      s = idle(); s.idOp = 6'b000100; s.idRs = 5'd5; s.memMemRead = 1'b1; s.memRd = 5'd5;
      applyStimulus(s);
      s = idle(); s.idOp = 6'b000101; s.idRt = 5'd7; s.exRegWrite = 1'b1; s.exRd = 5'd7;
      applyStimulus(s);
      s = idle(); s.idOp = 6'b000100; s.exRegWrite = 1'b1; s.exRd = 5'd0;
      applyStimulus(s);
      s = idle(); s.idOp = 6'b100011; s.idRs = 5'd5; s.exRegWrite = 1'b1; s.exRd = 5'd5;
      applyStimulus(s);

      // Random traffic on a small register set so that matches are frequent.
      for (int n = 0; n < 400; n++) begin
         s = idle();
         s.rstN       = ($urandom_range(0, 59) != 0);
         s.exMemRead  = ($urandom_range(0, 2) == 0);
         s.exRt       = REG_W'($urandom_range(0, 3));
         s.exRegWrite = ($urandom_range(0, 1) == 0);
         s.exRd       = REG_W'($urandom_range(0, 3));
         s.memMemRead = ($urandom_range(0, 2) == 0);
         s.memRd      = REG_W'($urandom_range(0, 3));
         s.idRs       = REG_W'($urandom_range(0, 3));
         s.idRt       = REG_W'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       s.idOp = 6'b000100;
            1:       s.idOp = 6'b000101;
            default: s.idOp = 6'b100011;
         endcase
         s.idMulDiv   = ($urandom_range(0, 5) == 0);
         s.idReadHiLo = ($urandom_range(0, 2) == 0);
         applyStimulus(s);
      end

      // Let the monitor consume the last entry, then confirm nothing is left.
      @(negedge clk);
      #1;
      checkCount++;
      if (expQ.size() == 0) passCount++;
      else $display("[TB] FAIL queueDrain: %0d entries left, expected 0", expQ.size());

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
